candy_sram_arb: RTL and testbench

Single-port SRAM arbiter and write buffer for the candy core. It shares the one SRAM port between three requesters: writeback-stage stores, memory-stage loads and the host loader. Writeback stores are posted into a small write buffer, and loads that hit a buffered address are forwarded from it. It sits between the wb/mem stages and the SRAM macro, replacing the direct wb-to-SRAM write path.

---
 rtl/candy_sram_arb_pkg.sv | 18 +
 rtl/candy_sram_arb_wbuf.sv | 93 +++++++++
 rtl/candy_sram_arb.sv | 183 ++++++++++++++++++
 tb/tb_candy_sram_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/candy_sram_arb_pkg.sv
// candy_sram_arb_pkg
// Shared widths and the grant encoding for the candy SRAM arbiter and its
// write buffer.
//   SRAM_ADDR_WIDTH / SRAM_DATA_WIDTH : SRAM macro word address and data widths
//   arb_gnt_e                         : owner of the SRAM port in a given cycle
package candy_sram_arb_pkg;

  localparam int SRAM_ADDR_WIDTH = 17;
  localparam int SRAM_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    ARB_GNT_NONE  = 2'd0,
    ARB_GNT_RD    = 2'd1,
    ARB_GNT_DRAIN = 2'd2,
    ARB_GNT_LD    = 2'd3
  } arb_gnt_e;

endpackage

// File: rtl/candy_sram_arb_wbuf.sv
// candy_sram_arb_wbuf
// In-order posted-write FIFO with a parallel address-compare port.
//   clk, rst              : clock, synchronous active-high reset (discards entries)
//   push, push_addr/data  : enqueue a store (ignored when full)
//   pop                   : dequeue the oldest entry (ignored when empty)
//   head_addr, head_data  : oldest entry, valid when !empty
//   empty, full           : registered occupancy flags
//   lookup_addr           : address compared against every live entry
//   hit, hit_data         : some live entry matches; data of the youngest match
module candy_sram_arb_wbuf
  import candy_sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [SRAM_ADDR_WIDTH-1:0] push_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] push_data,
  input  logic                       pop,
  output logic [SRAM_ADDR_WIDTH-1:0] head_addr,
  output logic [SRAM_DATA_WIDTH-1:0] head_data,
  output logic                       empty,
  output logic                       full,
  input  logic [SRAM_ADDR_WIDTH-1:0] lookup_addr,
  output logic                       hit,
  output logic [SRAM_DATA_WIDTH-1:0] hit_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SRAM_ADDR_WIDTH-1:0] addr_mem_reg [DEPTH];
  logic [SRAM_DATA_WIDTH-1:0] data_mem_reg [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic                       full_reg;
  logic [PTR_W:0]             occ;
  logic                       do_push;
  logic                       do_pop;
  logic [DEPTH-1:0]           match_vec;
  logic [PTR_W-1:0]           scan_idx;

  // Equal pointers are ambiguous; the full flag tells full from empty.
  assign empty   = (wr_ptr_reg == rd_ptr_reg) && !full_reg;
  assign full    = full_reg;
  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty;
  assign occ     = full_reg ? (PTR_W+1)'(DEPTH) : {1'b0, wr_ptr_reg - rd_ptr_reg};

  assign head_addr = addr_mem_reg[rd_ptr_reg];
  assign head_data = data_mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)
        full_reg <= ((wr_ptr_reg + 1'b1) == rd_ptr_reg);
      else if (do_pop && !do_push)
        full_reg <= 1'b0;
    end
  end

  // Storage carries no reset: liveness comes only from the pointers.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        addr_mem_reg[gi] <= push_addr;
        data_mem_reg[gi] <= push_data;
      end
    end
    assign match_vec[gi] = (addr_mem_reg[gi] == lookup_addr);
  end

  // Walk live entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = rd_ptr_reg;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_reg + PTR_W'(k);
      if (((PTR_W+1)'(k) < occ) && match_vec[scan_idx]) begin
        hit      = 1'b1;
        hit_data = data_mem_reg[scan_idx];
      end
    end
  end

endmodule

// File: rtl/candy_sram_arb.sv
// candy_sram_arb
// Shares the single SRAM port between posted writeback stores (through a
// write buffer), memory-stage loads and the host loader.
//   clk, rst                     : clock, synchronous active-high reset
//   wb_req/addr/data, wb_ready   : store posting into the write buffer
//   rd_req/addr, rd_ready        : core load issue
//   rd_valid, rd_data            : core load return, one cycle after rd_ready
//   ld_req/we/addr/wdata, ld_ack : host loader access
//   ld_rvalid, ld_rdata          : host read return, one cycle after ld_ack
//   sram_ce/we/addr/wdata        : SRAM strobe and write path
//   sram_rdata                   : SRAM read data, valid the cycle after a read
module candy_sram_arb
  import candy_sram_arb_pkg::*;
#(
  parameter int WBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wb_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] wb_data,
  output logic                       wb_ready,
  input  logic                       rd_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_ready,
  output logic                       rd_valid,
  output logic [SRAM_DATA_WIDTH-1:0] rd_data,
  input  logic                       ld_req,
  input  logic                       ld_we,
  input  logic [SRAM_ADDR_WIDTH-1:0] ld_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] ld_wdata,
  output logic                       ld_ack,
  output logic                       ld_rvalid,
  output logic [SRAM_DATA_WIDTH-1:0] ld_rdata,
  output logic                       sram_ce,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic                       wbuf_empty;
  logic                       wbuf_full;
  logic [SRAM_ADDR_WIDTH-1:0] head_addr;
  logic [SRAM_DATA_WIDTH-1:0] head_data;
  logic                       buf_hit;
  logic [SRAM_DATA_WIDTH-1:0] buf_hit_data;

  logic                       push;
  logic                       starve;
  logic                       rd_accept;
  logic                       push_hit;
  logic                       fwd;
  logic [SRAM_DATA_WIDTH-1:0] fwd_data;
  arb_gnt_e                   gnt;

  logic [WAIT_W-1:0]          wait_cnt_reg, wait_cnt_next;
  logic                       sram_rd_reg, sram_rd_next;
  logic                       owner_reg, owner_next;
  logic                       fwd_valid_reg, fwd_valid_next;
  logic [SRAM_DATA_WIDTH-1:0] fwd_data_reg, fwd_data_next;

  candy_sram_arb_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (wb_addr),
    .push_data   (wb_data),
    .pop         (gnt == ARB_GNT_DRAIN),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .empty       (wbuf_empty),
    .full        (wbuf_full),
    .lookup_addr (rd_addr),
    .hit         (buf_hit),
    .hit_data    (buf_hit_data)
  );

  // Every handshake is masked by rst so the block is silent while in reset.
  assign wb_ready  = !rst && !wbuf_full;
  assign push      = wb_req && wb_ready;
  assign starve    = !rst && ld_req && wbuf_empty &&
                     (wait_cnt_reg == WAIT_W'(STARVE_LIMIT));
  assign rd_accept = !rst && rd_req && !starve;
  assign rd_ready  = rd_accept;

  // The same-cycle push is newer than anything already buffered.
  assign push_hit  = push && (wb_addr == rd_addr);
  assign fwd       = rd_accept && (push_hit || buf_hit);
  assign fwd_data  = push_hit ? wb_data : buf_hit_data;

  // Loader normal path waits for an empty buffer so its reads see every store.
  always_comb begin
    gnt = ARB_GNT_NONE;
    if (rst)                   gnt = ARB_GNT_NONE;
    else if (starve)           gnt = ARB_GNT_LD;
    else if (rd_accept && !fwd) gnt = ARB_GNT_RD;
    else if (!wbuf_empty)      gnt = ARB_GNT_DRAIN;
    else if (ld_req)           gnt = ARB_GNT_LD;
  end

  assign ld_ack = (gnt == ARB_GNT_LD);

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (gnt)
      ARB_GNT_RD: begin
        sram_ce   = 1'b1;
        sram_addr = rd_addr;
      end
      ARB_GNT_DRAIN: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = head_addr;
        sram_wdata = head_data;
      end
      ARB_GNT_LD: begin
        sram_ce    = 1'b1;
        sram_we    = ld_we;
        sram_addr  = ld_addr;
        sram_wdata = ld_we ? ld_wdata : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!ld_req || ld_ack)
      wait_cnt_next = '0;
    else if (wait_cnt_reg != WAIT_W'(STARVE_LIMIT))
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Return path: owner_reg says whose SRAM read returns next cycle; a forward
  // is held one cycle so it lines up with SRAM read latency.
  always_comb begin
    sram_rd_next   = (gnt == ARB_GNT_RD) || ((gnt == ARB_GNT_LD) && !ld_we);
    owner_next     = (gnt == ARB_GNT_LD);
    fwd_valid_next = fwd;
    fwd_data_next  = fwd ? fwd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg  <= '0;
      sram_rd_reg   <= 1'b0;
      owner_reg     <= 1'b0;
      fwd_valid_reg <= 1'b0;
      fwd_data_reg  <= '0;
    end else begin
      wait_cnt_reg  <= wait_cnt_next;
      sram_rd_reg   <= sram_rd_next;
      owner_reg     <= owner_next;
      fwd_valid_reg <= fwd_valid_next;
      fwd_data_reg  <= fwd_data_next;
    end
  end

  assign rd_valid  = !rst && (fwd_valid_reg || (sram_rd_reg && !owner_reg));
  assign ld_rvalid = !rst && sram_rd_reg && owner_reg;

  always_comb begin
    rd_data = '0;
    if (!rst) begin
      if (fwd_valid_reg)
        rd_data = fwd_data_reg;
      else if (sram_rd_reg && !owner_reg)
        rd_data = sram_rdata;
    end
  end

  assign ld_rdata = ld_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_candy_sram_arb.sv
// tb_candy_sram_arb
// Scoreboard bench: a transaction-level model (logical memory, store queue,
// loader wait counter) predicts grants and read returns; a monitor pops the
// expected returns whenever the DUT raises a valid strobe.
module tb_candy_sram_arb;
  import candy_sram_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req, rd_req, ld_req, ld_we;
  logic [16:0] wb_addr, rd_addr, ld_addr;
  logic [23:0] wb_data, ld_wdata;
  logic        wb_ready, rd_ready, rd_valid, ld_ack, ld_rvalid;
  logic [23:0] rd_data, ld_rdata;
  logic        sram_ce, sram_we;
  logic [16:0] sram_addr;
  logic [23:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  candy_sram_arb #(.WBUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM macro; rdata is junk except the cycle after a read.
  logic [23:0] sram_mem [logic [16:0]];
  logic [23:0] lmem     [logic [16:0]];

  function automatic logic [23:0] sram_rd(input logic [16:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 24'h0;
  endfunction

  function automatic logic [23:0] lmem_rd(input logic [16:0] a);
    return lmem.exists(a) ? lmem[a] : 24'h0;
  endfunction

  always @(posedge clk) begin
    sram_rdata <= (sram_ce && !sram_we) ? sram_rd(sram_addr) : 24'($urandom);
    if (sram_ce && sram_we) sram_mem[sram_addr] = sram_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct { logic [16:0] a; logic [23:0] d; } st_t;
  typedef struct { int c; logic [23:0] d; } rt_t;
  st_t wq[$];
  rt_t rdq[$];
  rt_t ldq[$];
  int  wait_m = 0;

  function automatic bit in_wq(input logic [16:0] a);
    foreach (wq[i]) if (wq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Model scratch (assigned every cycle before use)
  int          m_occ, m_g;
  bit          m_push, m_starve, m_rdacc, m_fwd, m_we;
  logic [16:0] m_addr;
  logic [23:0] m_wdata;

  // Reference model and per-cycle grant checks; g: 0 none 1 read 2 drain 3 loader
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", 32'({wb_ready, rd_ready, rd_valid, ld_ack, ld_rvalid, sram_ce, sram_we}), 32'h0);
      chk("rst_data", 32'(rd_data | ld_rdata | sram_wdata), 32'h0);
      chk("rst_addr", 32'(sram_addr), 32'h0);
      wq.delete();
      rdq.delete();
      ldq.delete();
      wait_m = 0;
      lmem = sram_mem;
    end else begin
      m_occ    = wq.size();
      m_push   = wb_req && (m_occ < DEPTH);
      m_starve = ld_req && (wait_m == LIMIT) && (m_occ == 0);
      m_rdacc  = rd_req && !m_starve;
      m_fwd    = m_rdacc && ((m_push && wb_addr == rd_addr) || in_wq(rd_addr));
      if (m_starve)                m_g = 3;
      else if (m_rdacc && !m_fwd)  m_g = 1;
      else if (m_occ > 0)          m_g = 2;
      else if (ld_req)             m_g = 3;
      else                         m_g = 0;
      m_we    = (m_g == 2) || (m_g == 3 && ld_we);
      m_addr  = (m_g == 1) ? rd_addr : (m_g == 2) ? wq[0].a : (m_g == 3) ? ld_addr : 17'h0;
      m_wdata = (m_g == 2) ? wq[0].d : ld_wdata;

      chk("wb_ready", 32'(wb_ready), 32'(m_occ < DEPTH));
      chk("rd_ready", 32'(rd_ready), 32'(m_rdacc));
      chk("ld_ack", 32'(ld_ack), 32'(m_g == 3));
      chk("sram_ce", 32'(sram_ce), 32'(m_g != 0));
      if (m_g != 0) begin
        chk("sram_we", 32'(sram_we), 32'(m_we));
        chk("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (m_we) chk("sram_wdata", 32'(sram_wdata), 32'(m_wdata));
      end

      if (m_rdacc)
        rdq.push_back('{cyc, (m_push && wb_addr == rd_addr) ? wb_data : lmem_rd(rd_addr)});
      if (m_g == 3 && !ld_we)
        ldq.push_back('{cyc, lmem_rd(ld_addr)});

      if (m_g == 3 && ld_we) lmem[ld_addr] = ld_wdata;
      if (m_g == 2) void'(wq.pop_front());
      if (m_push) begin
        wq.push_back('{wb_addr, wb_data});
        lmem[wb_addr] = wb_data;
      end
      if (!ld_req || m_g == 3) wait_m = 0;
      else if (wait_m < LIMIT)  wait_m = wait_m + 1;
    end
  end

  // Monitor: consume expected returns whenever a valid strobe shows up.
  rt_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (rdq.size() == 0) chk("rd_valid_spurious", 32'(rd_valid), 32'h0);
        else begin
          mon_e = rdq.pop_front();
          chk("rd_latency", 32'(cyc), 32'(mon_e.c + 1));
          chk("rd_data", 32'(rd_data), 32'(mon_e.d));
          $display("[TB] cyc=%0d core read data=%h", cyc, rd_data);
        end
      end else if (rdq.size() > 0 && rdq[0].c < cyc) begin
        chk("rd_valid_missing", 32'(rd_valid), 32'h1);
        void'(rdq.pop_front());
      end
      if (ld_rvalid) begin
        if (ldq.size() == 0) chk("ld_rvalid_spurious", 32'(ld_rvalid), 32'h0);
        else begin
          mon_e = ldq.pop_front();
          chk("ld_latency", 32'(cyc), 32'(mon_e.c + 1));
          chk("ld_rdata", 32'(ld_rdata), 32'(mon_e.d));
          $display("[TB] cyc=%0d host read data=%h", cyc, ld_rdata);
        end
      end else if (ldq.size() > 0 && ldq[0].c < cyc) begin
        chk("ld_rvalid_missing", 32'(ld_rvalid), 32'h1);
        void'(ldq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_req = 1'b0; rd_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int  n, k, acc3;
  bit  got;

  initial begin
    rst = 1'b1;
    wb_req = 1'b1; rd_req = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
    wb_addr = 17'd5; rd_addr = 17'd5; ld_addr = 17'd6;
    wb_data = 24'h111111; ld_wdata = 24'h222222;
    tick(); tick();
    rst = 1'b0; idle_in(); tick();

    // Posted store
    wb_req = 1'b1; wb_addr = 17'd11; wb_data = 24'h37c549; tick();
    idle_in(); tick(); tick();
    chk("post_sram", 32'(sram_rd(17'd11)), 32'h37c549);

    // Forward from same-cycle push
    rd_req = 1'b1; rd_addr = 17'd11; wb_req = 1'b1; wb_addr = 17'd11; wb_data = 24'h37c549;
    tick(); idle_in(); tick(); tick();

    // Full back-pressure under continuous reads
    k = 0; n = 0; acc3 = -1;
    rd_req = 1'b1; rd_addr = 17'd200;
    while (k < 3 && n < 30) begin
      if (n == 6) rd_req = 1'b0;
      wb_req = 1'b1; wb_addr = 17'(300 + k); wb_data = 24'(24'h500000 + k);
      @(negedge clk);
      got = wb_ready;
      tick();
      if (got) begin
        if (k == 2) acc3 = n;
        k++;
      end
      n++;
    end
    idle_in();
    chk("full_all_accepted", 32'(k), 32'd3);
    chk("full_third_after_release", 32'(acc3 >= 6), 32'd1);
    repeat (4) tick();

    // Loader starvation
    rd_req = 1'b1; rd_addr = 17'd400; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 17'd11;
    n = 0; got = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      got = ld_ack;
      if (got) begin
        chk("starve_rd_ready", 32'(rd_ready), 32'h0);
        break;
      end
      tick();
      n++;
    end
    chk("starve_cycles", 32'(n), 32'(LIMIT));
    tick(); idle_in(); tick(); tick();

    // Loader coherence behind buffered stores
    rd_req = 1'b1; rd_addr = 17'd500;
    wb_req = 1'b1; wb_addr = 17'd20; wb_data = 24'haaaaaa; tick();
    wb_addr = 17'd21; wb_data = 24'hbbbbbb; tick();
    idle_in(); ld_req = 1'b1; ld_we = 1'b0; ld_addr = 17'd21;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      got = ld_ack;
      tick();
      if (got) break;
      n++;
    end
    idle_in();
    chk("coh_ack_after_drain", 32'(n), 32'd2);
    @(negedge clk);
    chk("coh_ld_rdata", 32'(ld_rdata), 32'hbbbbbb);
    tick(); tick();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 249) == 0);
      wb_req   = $urandom_range(0, 1) == 1;
      wb_addr  = 17'($urandom_range(0, 15));
      wb_data  = 24'($urandom);
      rd_req   = $urandom_range(0, 9) < 6;
      rd_addr  = 17'($urandom_range(0, 15));
      ld_req   = $urandom_range(0, 2) == 0;
      ld_we    = $urandom_range(0, 1) == 1;
      ld_addr  = 17'($urandom_range(0, 15));
      ld_wdata = 24'($urandom);
      tick();
    end
    rst = 1'b0; idle_in();
    repeat (6) tick();
    chk("rdq_empty_at_end", 32'(rdq.size()), 32'h0);
    chk("ldq_empty_at_end", 32'(ldq.size()), 32'h0);
    chk("wq_empty_at_end", 32'(wq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
